// File: rtl/lfsr_pkg.sv
// Shared definitions for the game random-stream checker: FSM encoding and the
// recurrence constants of the game generator's rand output.
package lfsr_pkg;

  typedef enum logic [1:0] {
    StSeed  = 2'd0,
    StCheck = 2'd1,
    StLost  = 2'd2
  } lfsr_state_e;

  // Game generator after its all-ones reset obeys s[n] = s[n-1] ^ s[n-8].
  localparam int unsigned GAME_LFSR_LEN = 8;
  localparam int unsigned GAME_TAP_A    = 1;
  localparam int unsigned GAME_TAP_B    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the game's pseudo-random bit stream: seeds its
// history from the line, then free-runs the reference recurrence and counts errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LEN    = GAME_LFSR_LEN,
  parameter int unsigned TAP_A  = GAME_TAP_A,
  parameter int unsigned TAP_B  = GAME_TAP_B,
  parameter int unsigned WIN    = 64,
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [7:0]       resync_count_o
);

  localparam int unsigned SeedW = $clog2(LEN + 1);
  localparam int unsigned WinW  = $clog2(WIN + 1);
  localparam int unsigned ErrW  = $clog2(THRESH + 1);

  lfsr_state_e      state_q, state_d;
  logic [LEN-1:0]   hist_q, hist_d;
  logic [SeedW-1:0] seed_cnt_q, seed_cnt_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d, win_cnt_inc;
  logic [ErrW-1:0]  win_err_q, win_err_d, win_err_inc;
  logic             err_q, err_d;
  logic             predict, mismatch;

  assign predict     = hist_q[TAP_A-1] ^ hist_q[TAP_B-1];
  assign mismatch    = in_bit_i ^ predict;
  assign win_cnt_inc = win_cnt_q + WinW'(1);
  assign win_err_inc = win_err_q + ErrW'(mismatch);

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    seed_cnt_d = seed_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    err_d      = 1'b0;
    unique case (state_q)
      StSeed: begin
        if (in_valid_i) begin
          hist_d     = {hist_q[LEN-2:0], in_bit_i};
          seed_cnt_d = seed_cnt_q + SeedW'(1);
          if (seed_cnt_q == SeedW'(LEN - 1)) begin
            seed_cnt_d = '0;
            // An all-zero history would lock the recurrence at zero forever.
            if (|hist_d) begin
              state_d   = StCheck;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end
        end
      end
      StCheck: begin
        if (in_valid_i) begin
          // Shift the prediction so one corrupted line bit is counted only once.
          hist_d = {hist_q[LEN-2:0], predict};
          err_d  = mismatch;
          if (win_err_inc >= ErrW'(THRESH)) begin
            state_d = StLost;
          end
          if (win_cnt_inc == WinW'(WIN)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = win_err_inc;
          end
        end
      end
      StLost: begin
        state_d    = StSeed;
        seed_cnt_d = '0;
      end
      default: begin
        state_d    = StSeed;
        seed_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSeed;
      hist_q     <= '0;
      seed_cnt_q <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      seed_cnt_q <= seed_cnt_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      err_q      <= err_d;
    end
  end

  assign locked_o    = (state_q == StCheck);
  assign lock_lost_o = (state_q == StLost);
  assign err_pulse_o = err_q;

  sat_counter #(
    .Width(CNT_W)
  ) u_err_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (err_d),
    .clr_i  (clear_i),
    .count_o(err_count_o)
  );

  sat_counter #(
    .Width(8)
  ) u_resync_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (state_q == StLost),
    .clr_i  (clear_i),
    .count_o(resync_count_o)
  );

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Serial receiver-side checker for the game's pseudo-random bit stream, used as built-in self-test of the random source driving the tug-of-war event logic. It consumes one bit per valid cycle and self-synchronises by seeding its history from the received bits. Once locked, it free-runs its own reference recurrence, counts mismatches, and drops lock and resynchronises when the error density is too high.

Parameters:
LEN, 8, recurrence history length in bits (s[n] depends on s[n-1..n-LEN])
TAP_A, 1, first feedback tap: s[n] = s[n-TAP_A] ^ s[n-TAP_B]
TAP_B, 8, second feedback tap; must satisfy 1 <= TAP_A < TAP_B <= LEN
WIN, 64, error-density window length, in valid bits
THRESH, 4, errors within one window that force loss of lock
CNT_W, 16, width of err_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  received random bit
clear  input  1  synchronous clear of err_count and resync_count
locked  output  1  checker synchronised (state CHECK)
err_pulse  output  1  one-cycle pulse per mismatched bit
lock_lost  output  1  one-cycle pulse when lock is dropped
err_count  output  CNT_W  saturating total mismatch count
resync_count  output  8  saturating count of lock losses

Behaviour:
- Reset: rst_n low asynchronously clears the history, all counters and all outputs to 0, and puts the FSM in SEED.
- History: hist[LEN-1:0]; hist[0] holds the most recent bit. Predicted bit p = hist[TAP_A-1] ^ hist[TAP_B-1].
- When in_valid = 0, nothing advances: no shift, no counting, no state change.
- FSM states: SEED, CHECK, LOST.
- SEED:
  - Each valid bit shifts in_bit into hist and increments seed_cnt.
  - When the LEN-th bit is taken: if the new history is nonzero, go to CHECK and clear the window counters.
  - If the new history is all-zero (lock-up seed), clear seed_cnt and stay in SEED.
  - No errors are counted in SEED.
- CHECK:
  - Each valid bit shifts p, not in_bit, into hist, so a single channel error is counted exactly once.
  - If in_bit != p: err_pulse = 1 on the next cycle (1-cycle latency, registered), err_count increments and saturates at all-ones, and win_err increments.
  - win_cnt counts valid bits; on the WIN-th bit both win_cnt and win_err reset to 0. The error test below uses the incremented win_err before this reset.
  - If win_err reaches THRESH, go to LOST.
- LOST: lasts exactly one cycle regardless of in_valid.
  - lock_lost = 1 during that cycle; resync_count increments, saturating at 255.
  - seed_cnt is cleared and the FSM goes to SEED.
  - A bit presented during LOST is ignored.
- locked is registered and equals (state == CHECK), so it rises one cycle after the seeding bit is accepted.
- clear:
  - Zeroes err_count and resync_count.
  - Does not touch the FSM, history or window counters.
  - If clear coincides with an increment, clear wins and the count is 0.
- Reset mid-operation forces SEED immediately, with all counters at 0.

Decomposition:
- Shared package lfsr_pkg:
  - FSM state encoding (SEED = 2'd0, CHECK = 2'd1, LOST = 2'd2).
  - Default tap and length constants: GAME_LFSR_LEN = 8, TAP_A = 1, TAP_B = 8. These are the recurrence of the game generator's rand output after its all-ones reset.
- One sub-module: sat_counter (parameterised width; inc, clr, clr-wins priority), instantiated for err_count and resync_count.

Test Plan:
- Reset the generator model (all-ones) and feed its stream: eight 1s then 0 -> locked rises the cycle after the 8th bit; 9th bit 0 raises no error; 1000 further correct bits leave err_count = 0.
- Once locked, invert one bit -> exactly one err_pulse the next cycle, err_count = 1, locked stays 1, and following correct bits raise no errors.
- Invert 4 bits within 64 valid bits -> lock_lost pulse, resync_count = 1, locked = 0; re-locks 8 valid bits later. 3 errors per 64-bit window never lose lock.
- Seed with eight 0s -> locked stays 0 and seed restarts; eight 1s afterwards -> locked = 1.
- Assert clear on the same cycle as an error -> err_count = 0. Hold in_valid = 0 for 20 cycles mid-CHECK -> no state or count change.
- Drop rst_n while locked with err_count = 5 -> all outputs 0 immediately and FSM in SEED. Force 65535 errors -> err_count holds at 0xFFFF.
